// File: rtl/pll_reset_seq.sv
// Reference-clock reset sequencer for the system PLL: pulses the PLL reset, waits for stable lock,
// then releases three domain resets in order. All outputs registered; lock is used only after a 2-flop synchronizer.
module pll_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 500000,
  parameter int unsigned STABLE_CYCLES  = 50000,
  parameter int unsigned STAGE_GAP      = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic [2:0] rst_out,
  output logic       ready,
  output logic [7:0] loss_count
);

  localparam int unsigned MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int unsigned MAX_C = (MAX_B > 2 * STAGE_GAP) ? MAX_B : 2 * STAGE_GAP;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAITLOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            sync1, locked_s;
  logic            pll_rst_nxt, ready_nxt, loss_inc;
  logic [2:0]      rst_out_nxt;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1      <= 1'b0;
      locked_s   <= 1'b0;
      state      <= S_PLLRST;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      rst_out    <= 3'b111;
      ready      <= 1'b0;
      loss_count <= 8'd0;
    end else begin
      sync1    <= locked_in;
      locked_s <= sync1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pll_rst  <= pll_rst_nxt;
      rst_out  <= rst_out_nxt;
      ready    <= ready_nxt;
      if (loss_inc && loss_count != 8'hFF)
        loss_count <= loss_count + 8'd1;
    end
  end

  // Loss of lock is checked before any count-based exit so it always wins a tie.
  always_comb begin
    state_nxt = state;
    loss_inc  = 1'b0;
    case (state)
      S_PLLRST:
        if (cnt == CW'(PLL_RST_CYCLES - 1)) state_nxt = S_WAITLOCK;
      S_WAITLOCK:
        if (locked_s)                            state_nxt = S_STABLE;
        else if (cnt == CW'(LOCK_TIMEOUT - 1))   state_nxt = S_PLLRST;
      S_STABLE:
        if (!locked_s)                           state_nxt = S_WAITLOCK;
        else if (cnt == CW'(STABLE_CYCLES - 1))  state_nxt = S_RELEASE;
      S_RELEASE:
        if (!locked_s) begin
          state_nxt = S_WAITLOCK;
          loss_inc  = 1'b1;
        end else if (cnt == CW'(2 * STAGE_GAP - 1)) begin
          state_nxt = S_RUN;
        end
      S_RUN:
        if (!locked_s) begin
          state_nxt = S_WAITLOCK;
          loss_inc  = 1'b1;
        end
      default:
        state_nxt = S_PLLRST;
    endcase

    if (state_nxt != state)  cnt_nxt = '0;
    else if (state == S_RUN) cnt_nxt = cnt;
    else                     cnt_nxt = cnt + CW'(1);

    // Outputs are decoded from the upcoming state so they land on the same edge as the transition.
    pll_rst_nxt = (state_nxt == S_PLLRST);
    ready_nxt   = (state_nxt == S_RUN);
    case (state_nxt)
      S_RELEASE: rst_out_nxt = (cnt_nxt >= CW'(STAGE_GAP)) ? 3'b100 : 3'b110;
      S_RUN:     rst_out_nxt = 3'b000;
      default:   rst_out_nxt = 3'b111;
    endcase
  end

endmodule
